uart_tx_packetizer: RTL and testbench

- Upstream feeder for the UART transmitter in the Navigation path.
- Accepts one fixed-width navigation message per handshake and serialises it into a framed byte stream: SYNC, LEN, payload bytes, CHECKSUM.
- Drives the transmitter's byte-level valid/ready handshake, so a receiver can resynchronise and validate each packet.

---
 rtl/uart_pkt_pkg.sv | 20 ++
 rtl/uart_tx_packetizer.sv | 120 ++++++++++++
 tb/tb_uart_tx_packetizer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared types and helpers for the navigation UART packetizer and its matching receiver.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        LEN     = 3'd2,
        SEQ     = 3'd3,
        PAYLOAD = 3'd4,
        CSUM    = 3'd5
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;

    // Modulo-256 running sum; carries out of bit 7 are dropped.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/uart_tx_packetizer.sv
// Frames one navigation message as SYNC, LEN, [SEQ], payload (MSB byte first), CHECKSUM.
// Optional macro UART_PKT_SEQ_EN inserts a wrapping sequence-number byte after LEN.
module uart_tx_packetizer
    import uart_pkt_pkg::*;
#(
    parameter int         PAYLOAD_BYTES = 4,
    parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE,
    parameter int         BITS_N        = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PAYLOAD_BYTES*8-1:0] pkt_data,
    input  logic                       pkt_valid,
    output logic                       pkt_ready,
    output logic [BITS_N-1:0]          tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy
);

    localparam int               IDX_W    = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [7:0]       LEN_BYTE = 8'(PAYLOAD_BYTES);

    if (BITS_N != 8) begin : g_bad_bits
        $error("uart_tx_packetizer: BITS_N must be 8");
    end
    if (PAYLOAD_BYTES < 1 || PAYLOAD_BYTES > 255) begin : g_bad_len
        $error("uart_tx_packetizer: PAYLOAD_BYTES must be 1..255");
    end

    state_t                          state, next_state;
    logic [PAYLOAD_BYTES-1:0][7:0]   payload;
    logic [IDX_W-1:0]                idx;
    logic [7:0]                      csum;
    logic [7:0]                      cur_byte;
    logic                            pkt_xfer, byte_xfer;

    assign pkt_xfer  = pkt_valid && pkt_ready;
    assign byte_xfer = tx_valid && tx_ready;
    assign cur_byte  = payload[idx];

`ifdef UART_PKT_SEQ_EN
    logic [7:0] seq_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pkt_xfer)  next_state = SYNC;
            SYNC:    if (byte_xfer) next_state = LEN;
`ifdef UART_PKT_SEQ_EN
            LEN:     if (byte_xfer) next_state = SEQ;
            SEQ:     if (byte_xfer) next_state = PAYLOAD;
`else
            LEN:     if (byte_xfer) next_state = PAYLOAD;
`endif
            PAYLOAD: if (byte_xfer && idx == '0) next_state = CSUM;
            CSUM:    if (byte_xfer) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // tx_data depends only on registered state, so it holds steady under backpressure.
    always_comb begin
        pkt_ready = (state == IDLE);
        tx_valid  = (state != IDLE);
        busy      = (state != IDLE);
        tx_data   = '0;
        case (state)
            SYNC:    tx_data = SYNC_BYTE;
            LEN:     tx_data = LEN_BYTE;
`ifdef UART_PKT_SEQ_EN
            SEQ:     tx_data = seq_cnt;
`endif
            PAYLOAD: tx_data = cur_byte;
            CSUM:    tx_data = csum;
            default: tx_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            payload <= '0;
            idx     <= '0;
            csum    <= '0;
        end else if (pkt_xfer) begin
            payload <= pkt_data;
            csum    <= '0;
        end else if (byte_xfer) begin
            case (state)
                LEN: begin
                    csum <= csum_add(csum, LEN_BYTE);
                    idx  <= IDX_LAST;
                end
`ifdef UART_PKT_SEQ_EN
                SEQ:     csum <= csum_add(csum, seq_cnt);
`endif
                PAYLOAD: begin
                    csum <= csum_add(csum, cur_byte);
                    idx  <= idx - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef UART_PKT_SEQ_EN
    always_ff @(posedge clk) begin
        if (rst)                             seq_cnt <= '0;
        else if (byte_xfer && state == CSUM) seq_cnt <= seq_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// Directed bench for uart_tx_packetizer: expected bytes queued at packet hand-off, popped on tx handshake.
module tb_uart_tx_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  tb_seq = 8'd0;

    uart_tx_packetizer #(.PAYLOAD_BYTES(4), .SYNC_BYTE(8'hAA), .BITS_N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference framing built independently from the message bytes.
    task automatic push_frame(input logic [31:0] d);
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'd4;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'd4);
`ifdef UART_PKT_SEQ_EN
        exp_q.push_back(tb_seq);
        sum = sum + tb_seq;
        tb_seq = tb_seq + 8'd1;
`endif
        for (int i = 3; i >= 0; i--) begin
            b = d[i*8 +: 8];
            exp_q.push_back(b);
            sum = sum + b;
        end
        exp_q.push_back(sum);
    endtask

    task automatic send(input logic [31:0] d);
        int n;
        n = 0;
        while (!pkt_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("pkt_ready_wait", {31'd0, pkt_ready}, 32'd1);
        pkt_data  = d;
        pkt_valid = 1'b1;
        push_frame(d);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, {31'd0, (n < 300)}, 32'd1);
    endtask

    // Byte-level monitor: every accepted byte must be the next expected one.
    always @(negedge clk) begin
        if (!rst && tx_valid) begin
            check("pkt_ready_low_in_frame", {31'd0, pkt_ready}, 32'd0);
            if (tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; pkt_data = '0; pkt_valid = 1'b0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pkt_ready", {31'd0, pkt_ready}, 32'd1);
        check("rst_tx_valid",  {31'd0, tx_valid},  32'd0);
        check("rst_tx_data",   {24'd0, tx_data},   32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        rst = 1'b0;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_ready_ignored", {31'd0, tx_valid}, 32'd0);

        // Basic frame: AA 04 01 02 03 04 0E
        send(32'h01020304);
        check("n1_tx_valid",  {31'd0, tx_valid},  32'd1);
        check("n1_pkt_ready", {31'd0, pkt_ready}, 32'd0);
        check("n1_busy",      {31'd0, busy},      32'd1);
        wait_idle("basic_done");

        // Checksum wrap: 04 + 4*FF = 0x400 -> 00
        send(32'hFFFFFFFF);
        wait_idle("wrap_done");

        // Backpressure on payload byte 02
        send(32'h01020304);
        repeat (3) @(posedge clk);
        #1;
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_tx_data",  {24'd0, tx_data},  32'h02);
            check("bp_tx_valid", {31'd0, tx_valid}, 32'd1);
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        wait_idle("bp_done");

        // New packet offered while busy must wait for IDLE
        send(32'h11223344);
        pkt_valid = 1'b1;
        pkt_data  = 32'h55667788;
        check("busy_ignore_ready", {31'd0, pkt_ready}, 32'd0);
        begin
            int n;
            n = 0;
            while (!pkt_ready && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("busy_accept_idle",  {31'd0, busy}, 32'd0);
        check("busy_first_drained", exp_q.size(), 32'd0);
        push_frame(32'h55667788);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        wait_idle("busy_second_done");

        // Reset during PAYLOAD (showing byte 03)
        send(32'h01020304);
        repeat (4) @(posedge clk);
        #1;
        check("mid_tx_data", {24'd0, tx_data}, 32'h03);
        rst = 1'b1;
        tx_ready = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_tx_valid",  {31'd0, tx_valid},  32'd0);
        check("mid_rst_pkt_ready", {31'd0, pkt_ready}, 32'd1);
        check("mid_rst_busy",      {31'd0, busy},      32'd0);
        exp_q.delete();
        tb_seq = 8'd0;
        rst = 1'b0;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        send(32'h01020304);
        wait_idle("post_rst_done");

        // Three zero packets (exercise sequence numbering when enabled)
        for (int k = 0; k < 3; k++) begin
            send(32'h00000000);
            wait_idle("zero_done");
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty_end", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
